grant_index_encoder: RTL and testbench

//   Consumer end of the 36-way MSB-priority arbiter. Takes the one-hot grant vector

---
 rtl/grant_index_encoder_pkg.sv | 21 ++
 rtl/grant_index_encoder_if.sv | 30 +++
 rtl/grant_index_encoder_onehot_enc.sv | 39 +++
 rtl/grant_index_encoder.sv | 92 +++++++++
 tb/tb_grant_index_encoder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/grant_index_encoder_pkg.sv
// Shared types and sizes for the grant index encoder slice.
// Optional one-hot checking is enabled with macro ONEHOT_CHECK_EN.
`default_nettype none

package grant_pkg;

  localparam int N_CELLS = 36;
  localparam int IDX_W   = $clog2(N_CELLS);
  localparam int CNT_W   = 8;

  typedef logic [N_CELLS-1:0] grant_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } oreg_state_t;

endpackage

`default_nettype wire

// File: rtl/grant_index_encoder_if.sv
// Grant-in / index-out handshake bundle for grant_index_encoder.
// err_cnt and idx_err read as zero unless ONEHOT_CHECK_EN is defined.
`default_nettype none

interface grant_index_encoder_if;
  import grant_pkg::*;

  logic               g_valid;
  logic               g_ready;
  grant_t             g;
  logic               idx_valid;
  logic               idx_ready;
  idx_t               idx;
  logic               idx_none;
  logic               idx_err;
  logic [CNT_W-1:0]   err_cnt;

  modport slave (
    input  g_valid, g, idx_ready,
    output g_ready, idx_valid, idx, idx_none, idx_err, err_cnt
  );

  modport master (
    output g_valid, g, idx_ready,
    input  g_ready, idx_valid, idx, idx_none, idx_err, err_cnt
  );

endinterface

`default_nettype wire

// File: rtl/grant_index_encoder_onehot_enc.sv
// Combinational grant-vector to index encoder (OR of set-bit indices).
// The multi-hot flag exists only when ONEHOT_CHECK_EN is defined.
`default_nettype none

module onehot_enc
  import grant_pkg::*;
(
  input  grant_t i_g,
  output idx_t   o_idx,
  output logic   o_none
`ifdef ONEHOT_CHECK_EN
  ,
  output logic   o_multi
`endif
);

  idx_t w_idx;

  // OR-ing indices gives the exact position for one-hot input with no priority chain.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (i_g[i]) begin
        w_idx = w_idx | idx_t'(i);
      end
    end
  end

  assign o_idx  = w_idx;
  assign o_none = ~|i_g;

`ifdef ONEHOT_CHECK_EN
  // Clearing the lowest set bit leaves something only if more than one bit was set.
  assign o_multi = |(i_g & (i_g - grant_t'(1)));
`endif

endmodule

`default_nettype wire

// File: rtl/grant_index_encoder.sv
// Registers the encoded grant index behind a one-deep valid/ready output stage.
// Macro ONEHOT_CHECK_EN adds multi-hot flagging and a saturating error counter.
`default_nettype none

module grant_index_encoder
  import grant_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  grant_index_encoder_if.slave  bus
);

  oreg_state_t r_state;
  oreg_state_t w_state_nxt;
  idx_t        r_idx;
  logic        r_none;
  idx_t        w_idx;
  logic        w_none;
  logic        w_capture;

  assign bus.g_ready = (r_state == EMPTY) | bus.idx_ready;
  assign w_capture   = bus.g_valid & bus.g_ready;

`ifdef ONEHOT_CHECK_EN
  logic w_multi;

  onehot_enc u_enc (
    .i_g     (bus.g),
    .o_idx   (w_idx),
    .o_none  (w_none),
    .o_multi (w_multi)
  );
`else
  onehot_enc u_enc (
    .i_g    (bus.g),
    .o_idx  (w_idx),
    .o_none (w_none)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (bus.g_valid) w_state_nxt = FULL;
      FULL:  if (bus.idx_ready && !bus.g_valid) w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_idx   <= '0;
      r_none  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_idx  <= w_idx;
        r_none <= w_none;
      end
    end
  end

  assign bus.idx_valid = (r_state == FULL);
  assign bus.idx       = r_idx;
  assign bus.idx_none  = r_none;

`ifdef ONEHOT_CHECK_EN
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_capture) begin
      r_err <= w_multi;
      if (w_multi && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.idx_err = r_err;
  assign bus.err_cnt = r_cnt;
`else
  assign bus.idx_err = 1'b0;
  assign bus.err_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_grant_index_encoder.sv
// Self-checking bench for grant_index_encoder; expectations follow ONEHOT_CHECK_EN.
`default_nettype none

module tb_grant_index_encoder;
  import grant_pkg::*;

`ifdef ONEHOT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  grant_index_encoder_if bus_if ();

  grant_index_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference output register: what downstream should currently see.
  logic             m_valid;
  idx_t             m_idx;
  logic             m_none;
  logic             m_err;
  int               m_cnt;

  function automatic idx_t ref_idx(input grant_t g);
    int r;
    r = 0;
    for (int i = 0; i < N_CELLS; i++) if (g[i]) r = r | i;
    return idx_t'(r);
  endfunction

  function automatic grant_t bit_g(input int b);
    grant_t v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic grant_t rand_g();
    grant_t v;
    int a, b;
    v = '0;
    case ($urandom_range(0, 3))
      0: v = '0;
      1: v = bit_g($urandom_range(0, N_CELLS-1));
      2: begin
        a = $urandom_range(0, N_CELLS-1);
        b = (a + $urandom_range(1, N_CELLS-1)) % N_CELLS;
        v = bit_g(a) | bit_g(b);
      end
      default: v = grant_t'({$urandom, $urandom});
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = '0;
    m_none  = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic tick();
    bit ready;
    bit multi;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      ready = !m_valid || bus_if.idx_ready;
      if (bus_if.g_valid && ready) begin
        multi   = $countones(bus_if.g) > 1;
        m_valid = 1'b1;
        m_idx   = ref_idx(bus_if.g);
        m_none  = (bus_if.g == '0);
        m_err   = CHK_EN && multi;
        if (CHK_EN && multi && m_cnt < 255) m_cnt++;
      end else if (bus_if.idx_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input grant_t g, input logic rdy);
    bus_if.g_valid   = v;
    bus_if.g         = g;
    bus_if.idx_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus_if.idx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", bus_if.idx_valid); end
    n_checks++;
    if (bus_if.idx !== idx_t'(0)) begin n_errors++; $display("FAIL reset_idx got %0d want 0", bus_if.idx); end
    n_checks++;
    if ({bus_if.idx_none, bus_if.idx_err} !== 2'b00) begin n_errors++; $display("FAIL reset_flags got %b want 00", {bus_if.idx_none, bus_if.idx_err}); end
    n_checks++;
    if (bus_if.err_cnt !== '0) begin n_errors++; $display("FAIL reset_cnt got %0d want 0", bus_if.err_cnt); end
    n_checks++;
    if (bus_if.g_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", bus_if.g_ready); end
  endtask

  task automatic test_msb();
    drive(1'b1, 36'h8_0000_0000, 1'b1);
    tick();
    n_checks++;
    if ({bus_if.idx_valid, bus_if.idx, bus_if.idx_none} !== {1'b1, idx_t'(35), 1'b0}) begin
      n_errors++;
      $display("FAIL msb got v=%b idx=%0d none=%b want v=1 idx=35 none=0", bus_if.idx_valid, bus_if.idx, bus_if.idx_none);
    end
  endtask

  task automatic test_back_to_back();
    int pos [3] = '{0, 17, 34};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, bit_g(pos[k]), 1'b1);
      n_checks++;
      if (bus_if.g_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready got %b want 1", bus_if.g_ready); end
      tick();
      n_checks++;
      if ({bus_if.idx_valid, bus_if.idx} !== {1'b1, idx_t'(pos[k])}) begin
        n_errors++;
        $display("FAIL b2b_idx got v=%b idx=%0d want v=1 idx=%0d", bus_if.idx_valid, bus_if.idx, pos[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, bit_g(5), 1'b1);
    tick();
    drive(1'b1, bit_g(9), 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (bus_if.g_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready got %b want 0", bus_if.g_ready); end
      tick();
      n_checks++;
      if ({bus_if.idx_valid, bus_if.idx} !== {1'b1, idx_t'(5)}) begin
        n_errors++;
        $display("FAIL bp_hold got v=%b idx=%0d want v=1 idx=5", bus_if.idx_valid, bus_if.idx);
      end
    end
    drive(1'b1, bit_g(9), 1'b1);
    tick();
    n_checks++;
    if ({bus_if.idx_valid, bus_if.idx} !== {1'b1, idx_t'(9)}) begin
      n_errors++;
      $display("FAIL bp_release got v=%b idx=%0d want v=1 idx=9", bus_if.idx_valid, bus_if.idx);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    n_checks++;
    if (bus_if.idx_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain got %b want 0", bus_if.idx_valid); end
  endtask

  task automatic test_zero();
    drive(1'b1, '0, 1'b1);
    tick();
    n_checks++;
    if ({bus_if.idx_valid, bus_if.idx, bus_if.idx_none, bus_if.idx_err} !== {1'b1, idx_t'(0), 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL zero got v=%b idx=%0d none=%b err=%b want v=1 idx=0 none=1 err=0",
               bus_if.idx_valid, bus_if.idx, bus_if.idx_none, bus_if.idx_err);
    end
  endtask

  task automatic test_multihot();
    int a, b;
    drive(1'b1, bit_g(3) | bit_g(8), 1'b1);
    tick();
    n_checks++;
    if ({bus_if.idx, bus_if.idx_err, bus_if.idx_none} !== {idx_t'(11), CHK_EN, 1'b0}) begin
      n_errors++;
      $display("FAIL multi_first got idx=%0d err=%b none=%b want idx=11 err=%b none=0",
               bus_if.idx, bus_if.idx_err, bus_if.idx_none, CHK_EN);
    end
    n_checks++;
    if (bus_if.err_cnt !== (CHK_EN ? 8'd1 : 8'd0)) begin
      n_errors++;
      $display("FAIL multi_cnt1 got %0d want %0d", bus_if.err_cnt, CHK_EN ? 1 : 0);
    end
    for (int k = 0; k < 300; k++) begin
      a = $urandom_range(0, N_CELLS-1);
      b = (a + $urandom_range(1, N_CELLS-1)) % N_CELLS;
      drive(1'b1, bit_g(a) | bit_g(b), 1'b1);
      tick();
    end
    n_checks++;
    if (bus_if.err_cnt !== (CHK_EN ? 8'd255 : 8'd0)) begin
      n_errors++;
      $display("FAIL multi_sat got %0d want %0d", bus_if.err_cnt, CHK_EN ? 255 : 0);
    end
    n_checks++;
    if (bus_if.idx_err !== CHK_EN) begin n_errors++; $display("FAIL multi_flag got %b want %b", bus_if.idx_err, CHK_EN); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, bit_g(20), 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.idx_valid, bus_if.idx} !== {1'b0, idx_t'(0)}) begin
      n_errors++;
      $display("FAIL async_rst got v=%b idx=%0d want v=0 idx=0", bus_if.idx_valid, bus_if.idx);
    end
    n_checks++;
    if (bus_if.err_cnt !== '0) begin n_errors++; $display("FAIL async_rst_cnt got %0d want 0", bus_if.err_cnt); end
    model_reset();
    tick();
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      tick();
      n_checks++;
      if ({bus_if.idx_valid, bus_if.idx, bus_if.idx_none, bus_if.idx_err} !== {m_valid, m_idx, m_none, m_err}) begin
        n_errors++;
        $display("FAIL rand_out cyc=%0d got v=%b idx=%0d none=%b err=%b want v=%b idx=%0d none=%b err=%b", k,
                 bus_if.idx_valid, bus_if.idx, bus_if.idx_none, bus_if.idx_err, m_valid, m_idx, m_none, m_err);
      end
      n_checks++;
      if (bus_if.err_cnt !== 8'(m_cnt)) begin
        n_errors++;
        $display("FAIL rand_cnt cyc=%0d got %0d want %0d", k, bus_if.err_cnt, m_cnt);
      end
      drive(1'($urandom_range(0, 3) != 0), rand_g(), 1'($urandom_range(0, 2) != 0));
      #1;
      n_checks++;
      if (bus_if.g_ready !== (!m_valid || bus_if.idx_ready)) begin
        n_errors++;
        $display("FAIL rand_ready cyc=%0d got %b want %b", k, bus_if.g_ready, !m_valid || bus_if.idx_ready);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_msb();
    test_back_to_back();
    test_backpressure();
    test_zero();
    test_multihot();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
